// File: rtl/bcd_countdown_pkg.sv
// Shared types and constants for the cascaded BCD countdown timer.
package bcd_countdown_pkg;

  localparam int              BCD_W        = 4;
  localparam logic [BCD_W-1:0] BCD_MAX      = 4'd9;
  localparam logic [BCD_W-1:0] SEC_TENS_MAX = 4'd5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  function automatic logic [BCD_W-1:0] clamp_digit(input logic [BCD_W-1:0] v,
                                                   input logic [BCD_W-1:0] mx);
    return (v > mx) ? mx : v;
  endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD down-counting digit; borrows (and reloads MAXVAL) when decremented at zero.
module bcd_down_digit
  import bcd_countdown_pkg::*;
(
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             LOAD,
  input  logic [BCD_W-1:0] LDVAL,
  input  logic             DEC,
  input  logic [BCD_W-1:0] MAXVAL,
  output logic [BCD_W-1:0] Q,
  output logic             BORROW
);

  logic [BCD_W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (LOAD)
      q_d = LDVAL;
    else if (DEC)
      q_d = (q_q == '0) ? MAXVAL : q_q - 4'd1;
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) q_q <= '0;
    else       q_q <= q_d;
  end

  assign Q      = q_q;
  assign BORROW = DEC && (q_q == '0);

endmodule

// File: rtl/bcd_countdown.sv
// Cascaded BCD countdown timer: FSM, load clamping, zero detect and DONE pulse.
// Define BCD_COUNTDOWN_MMSS_EN to make digit 1 a 0..5 tens-of-seconds digit (MM:SS).
module bcd_countdown #(
  parameter int DIGITS = 4
) (
  input  logic                CLOCK,
  input  logic                RESET,
  input  logic                TICK,
  input  logic                LOAD,
  input  logic [4*DIGITS-1:0] DATA,
  input  logic                START,
  input  logic                PAUSE,
  output logic [4*DIGITS-1:0] Q,
  output logic                RUN,
  output logic                DONE,
  output logic                EXPIRED
);
  import bcd_countdown_pkg::*;

`ifdef BCD_COUNTDOWN_MMSS_EN
  localparam logic [BCD_W-1:0] DIGIT1_MAX = SEC_TENS_MAX;
`else
  localparam logic [BCD_W-1:0] DIGIT1_MAX = BCD_MAX;
`endif
  localparam logic [4*DIGITS-1:0] Q_ONE = (4*DIGITS)'(1);

  state_t state_q, state_d;
  logic   done_q, done_d;
  logic   running, q_zero, q_is_one, dec0;
  logic   [DIGITS:0] borrow;
  logic   unused_top_borrow;

  assign running  = (state_q == RUNNING);
  assign q_zero   = (Q == '0);
  assign q_is_one = (Q == Q_ONE);
  // Higher-priority controls in the same cycle swallow the tick.
  assign dec0     = TICK && running && !LOAD && !PAUSE;
  assign borrow[0] = dec0;
  assign unused_top_borrow = borrow[DIGITS];

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    localparam logic [BCD_W-1:0] MAXV = (i == 1) ? DIGIT1_MAX : BCD_MAX;
    bcd_down_digit u_digit (
      .CLOCK  (CLOCK),
      .RESET  (RESET),
      .LOAD   (LOAD),
      .LDVAL  (clamp_digit(DATA[i*BCD_W +: BCD_W], MAXV)),
      .DEC    (borrow[i]),
      .MAXVAL (MAXV),
      .Q      (Q[i*BCD_W +: BCD_W]),
      .BORROW (borrow[i+1])
    );
  end

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    if (LOAD) begin
      state_d = IDLE;
    end else if (START && (state_q == IDLE || state_q == PAUSED)) begin
      if (q_zero) begin
        state_d = bcd_countdown_pkg::EXPIRED;
        done_d  = 1'b1;
      end else begin
        state_d = RUNNING;
      end
    end else if (PAUSE && running) begin
      state_d = PAUSED;
    end else if (dec0 && q_is_one) begin
      // This decrement lands on zero: expire on the same edge.
      state_d = bcd_countdown_pkg::EXPIRED;
      done_d  = 1'b1;
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  assign RUN     = running;
  assign DONE    = done_q;
  assign EXPIRED = (state_q == bcd_countdown_pkg::EXPIRED);

endmodule

// File: tb/tb_bcd_countdown.sv
// Directed self-checking bench for bcd_countdown (honours BCD_COUNTDOWN_MMSS_EN).
module tb_bcd_countdown;

  logic        CLOCK = 1'b0;
  logic        RESET = 1'b0;
  logic        TICK  = 1'b0;
  logic        LOAD  = 1'b0;
  logic [15:0] DATA  = 16'h0;
  logic        START = 1'b0;
  logic        PAUSE = 1'b0;
  logic [15:0] Q;
  logic        RUN, DONE, EXPIRED;

  int tests = 0;
  int fails = 0;

  bcd_countdown #(.DIGITS(4)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .TICK(TICK), .LOAD(LOAD), .DATA(DATA),
    .START(START), .PAUSE(PAUSE), .Q(Q), .RUN(RUN), .DONE(DONE), .EXPIRED(EXPIRED)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic clk1();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_st(input string tag, input logic [15:0] q, input logic r,
                        input logic d, input logic e);
    chk({tag, ".q"},   Q,              q);
    chk({tag, ".run"}, {15'd0, RUN},   {15'd0, r});
    chk({tag, ".dn"},  {15'd0, DONE},  {15'd0, d});
    chk({tag, ".exp"}, {15'd0, EXPIRED}, {15'd0, e});
  endtask

  task automatic do_load(input logic [15:0] v);
    DATA = v; LOAD = 1'b1; clk1(); LOAD = 1'b0;
  endtask

  task automatic do_start();
    START = 1'b1; clk1(); START = 1'b0;
  endtask

  initial begin
    RESET = 1'b1; clk1(); RESET = 1'b0;
    chk_st("reset", 16'h0000, 0, 0, 0);

    do_load(16'h0003);
    chk_st("ld3", 16'h0003, 0, 0, 0);
    do_start();
    chk_st("st3", 16'h0003, 1, 0, 0);
    TICK = 1'b1;
    clk1(); chk_st("t1", 16'h0002, 1, 0, 0);
    clk1(); chk_st("t2", 16'h0001, 1, 0, 0);
    clk1(); chk_st("t3", 16'h0000, 0, 1, 1);
    clk1(); chk_st("t4", 16'h0000, 0, 0, 1);
    TICK = 1'b0;

    do_load(16'h1000);
    chk_st("ld1000", 16'h1000, 0, 0, 0);
    do_start();
    TICK = 1'b1; clk1(); TICK = 1'b0;
`ifdef BCD_COUNTDOWN_MMSS_EN
    chk_st("b1000", 16'h0959, 1, 0, 0);
`else
    chk_st("b1000", 16'h0999, 1, 0, 0);
`endif

    do_load(16'h0100); do_start();
    TICK = 1'b1; clk1(); TICK = 1'b0;
`ifdef BCD_COUNTDOWN_MMSS_EN
    chk_st("b0100", 16'h0059, 1, 0, 0);
`else
    chk_st("b0100", 16'h0099, 1, 0, 0);
`endif

    do_load(16'h2000); do_start();
    TICK = 1'b1; clk1(); TICK = 1'b0;
`ifdef BCD_COUNTDOWN_MMSS_EN
    chk_st("b2000", 16'h1959, 1, 0, 0);
`else
    chk_st("b2000", 16'h1999, 1, 0, 0);
`endif

    // pause/resume, with PAUSE+TICK in the same cycle
    do_load(16'h0005); do_start();
    TICK = 1'b1; clk1(); clk1();
    chk_st("p2t", 16'h0003, 1, 0, 0);
    PAUSE = 1'b1; clk1(); PAUSE = 1'b0;
    chk_st("pause", 16'h0003, 0, 0, 0);
    clk1(); clk1(); clk1();
    chk_st("phold", 16'h0003, 0, 0, 0);
    TICK = 1'b0; do_start();
    chk_st("resume", 16'h0003, 1, 0, 0);
    TICK = 1'b1; clk1(); TICK = 1'b0;
    chk_st("rt", 16'h0002, 1, 0, 0);

    START = 1'b1; PAUSE = 1'b1; clk1(); START = 1'b0; PAUSE = 1'b0;
    chk_st("stpa", 16'h0002, 0, 0, 0);
    do_start();
    TICK = 1'b1; DATA = 16'h0007; LOAD = 1'b1; clk1(); LOAD = 1'b0; TICK = 1'b0;
    chk_st("ldtk", 16'h0007, 0, 0, 0);

    do_load(16'h0000); do_start();
    chk_st("z", 16'h0000, 0, 1, 1);
    TICK = 1'b1; clk1(); TICK = 1'b0;
    chk_st("zt", 16'h0000, 0, 0, 1);
    do_start();
    chk_st("zs", 16'h0000, 0, 0, 1);

    do_load(16'h00AF);
`ifdef BCD_COUNTDOWN_MMSS_EN
    chk_st("clampAF", 16'h0059, 0, 0, 0);
`else
    chk_st("clampAF", 16'h0099, 0, 0, 0);
`endif
    do_load(16'hFFFF);
`ifdef BCD_COUNTDOWN_MMSS_EN
    chk_st("clampFF", 16'h9959, 0, 0, 0);
`else
    chk_st("clampFF", 16'h9999, 0, 0, 0);
`endif

    do_load(16'h0050); do_start();
    TICK = 1'b1; RESET = 1'b1; clk1(); RESET = 1'b0; TICK = 1'b0;
    chk_st("rstrun", 16'h0000, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bcd_countdown.md
# bcd_countdown

Cascaded BCD down-counter with load, start/pause control and an expiry pulse. It is the countdown (timer) counterpart of the stopwatch's up-counting 163-style chain. It decrements a preset BCD value once per external TICK until it reaches zero, then raises DONE. It sits between the time-base divider (TICK source) and the display multiplexer (Q consumer).

## Interface
- DIGITS, 4, number of cascaded BCD digits; digit 0 is least significant.
- CLOCK  input  1  system clock; all state changes on rising edge.
- RESET  input  1  synchronous, active-high reset.
- TICK  input  1  single-cycle count enable from the time base; ignored unless the block is running.
- LOAD  input  1  load DATA into Q and go to IDLE.
- DATA  input  4*DIGITS  preset value; nibble i is digit i.
- START  input  1  begin or resume counting.
- PAUSE  input  1  suspend counting; Q holds.
- Q  output  4*DIGITS  current BCD value.
- RUN  output  1  high in RUNNING.
- DONE  output  1  one-cycle pulse when the count reaches zero.
- EXPIRED  output  1  level, high in EXPIRED until LOAD or RESET.

## Operation
- States: IDLE, RUNNING, PAUSED, EXPIRED.
- Reset values: state=IDLE, Q=0, RUN=0, DONE=0, EXPIRED=0.
- Per-cycle priority: RESET > LOAD > START > PAUSE > TICK.
- LOAD, from any state:
  - Q←DATA with per-digit clamping; any nibble >9 loads as 9.
  - Next state is IDLE.
  - DONE and EXPIRED are cleared.
- START:
  - From IDLE or PAUSED with Q≠0: go to RUNNING.
  - From IDLE or PAUSED with Q=0: go to EXPIRED and pulse DONE.
  - In RUNNING or EXPIRED: ignored.
- PAUSE in RUNNING: go to PAUSED. Ignored in all other states.
- TICK in RUNNING: Q decrements by 1 in BCD.
  - A digit at 0 becomes 9 and borrows from the next digit.
  - A digit at 1..9 decrements and does not borrow.
- Zero detection: when a decrement produces Q=0, the state goes to EXPIRED and DONE pulses on the same edge. Q never wraps below zero.
- EXPIRED: Q holds 0. TICK, START and PAUSE are ignored.
- Simultaneous inputs in RUNNING:
  - START+PAUSE: PAUSE wins, since START is a no-op in RUNNING.
  - PAUSE+TICK: PAUSE wins and no decrement occurs.
  - LOAD+TICK: the load wins and no decrement occurs.
- Reset mid-count: the next edge produces the reset values, and the TICK arriving in that cycle is lost.

## Timing
- The decrement is registered: Q changes on the edge that samples TICK=1, giving one cycle latency.
- The borrow chain is combinational across all DIGITS within one cycle.
- DONE is registered and high for exactly one cycle. It is never asserted in consecutive cycles.
- RUN and EXPIRED are decoded from registered state, so they are glitch-free.
- TICK may be asserted in consecutive cycles; each asserted cycle decrements once.

## Configuration
- Macro: BCD_COUNTDOWN_MMSS_EN.
- When defined:
  - Digit 1 is a tens-of-seconds digit with range 0..5. On borrow it reloads 5, not 9.
  - On LOAD, digit 1 clamps values >5 to 5.
  - The display reads MM:SS for DIGITS=4.
- When undefined: all digits are plain 0..9 decimal digits.
- The macro only affects digit 1. Zero detection and the FSM are unchanged.

## Structure
- Package bcd_countdown_pkg holds:
  - state enum {IDLE, RUNNING, PAUSED, EXPIRED};
  - BCD_W=4;
  - BCD_MAX=9 and SEC_TENS_MAX=5.
- Sub-module bcd_down_digit:
  - Ports: CLOCK, RESET, LOAD, LDVAL, DEC, MAXVAL, Q, BORROW.
  - BORROW = DEC && Q==0.
  - Instantiated DIGITS times in a generate loop. Digit i's DEC is the borrow out of digit i-1. Digit 0's DEC is TICK && RUNNING.
- The top level holds the FSM, clamping, zero detect and DONE register.

## Test plan
- RESET then LOAD DATA=16'h0003, START, 3 TICKs → Q steps to 0002, 0001, 0000. DONE pulses once on the third-TICK edge, and EXPIRED=1.
- LOAD 16'h1000, START, 1 TICK → Q=0999, with no DONE.
- With the macro defined: LOAD 16'h0100, START, 1 TICK → Q=0059.
- LOAD 16'h0005, START, 2 TICKs, PAUSE, 3 TICKs, START, 1 TICK → Q=0003, then holds at 0003, then becomes 0002. RUN is low while paused.
- LOAD 16'h0000 then START → EXPIRED next edge and DONE pulses once. A further TICK leaves Q=0000.
- LOAD 16'h00AF → Q=0099.
- During RUNNING, RESET asserted together with TICK → all outputs at reset values next edge.
